// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with an IDLE/EXEC/FINISH handshake.
// Add/sub/logic/shift finish after one EXEC cycle. Mul (shift-add) and div/mod
// (restoring) resolve one bit per cycle and take NUM_BITS EXEC cycles.
// Optional feature: define SEQ_ALU_ASR_EN to make opcode 4'b1101 an
// arithmetic right shift; otherwise 4'b1101 behaves as an undefined opcode.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   start, A, B, S - request strobe, operands and opcode (sampled in IDLE only)
//   busy, done     - busy in EXEC/FINISH, done is a one-cycle pulse in FINISH
//   R, N, Z, C, V  - registered result and flags, updated on entry to FINISH
module seq_alu #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NUM_BITS-1:0] A,
  input  logic [NUM_BITS-1:0] B,
  input  logic [3:0]          S,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] R,
  output logic                N,
  output logic                Z,
  output logic                C,
  output logic                V
);

  localparam int CW  = $clog2(NUM_BITS);
  localparam int MSB = NUM_BITS - 1;
  localparam logic [NUM_BITS-1:0] WIDTH_V = NUM_BITS'(NUM_BITS);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_LSL = 4'b1011;
  localparam logic [3:0] OP_LSR = 4'b1100;
`ifdef SEQ_ALU_ASR_EN
  localparam logic [3:0] OP_ASR = 4'b1101;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, FINISH} state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] a_q, b_q;
  logic [3:0]          op_q;
  // Shared iterative working pair: mul keeps {partial high, multiplier/low},
  // div/mod keep {remainder, dividend/quotient}.
  logic [NUM_BITS-1:0] hi_q, lo_q;
  logic [CW-1:0]       cnt_q;
  logic [NUM_BITS-1:0] r_q;
  logic                n_q, z_q, c_q, v_q;

  logic                multi;
  logic [NUM_BITS:0]   mul_sum;
  logic [NUM_BITS-1:0] mul_hi, mul_lo;
  logic [NUM_BITS:0]   div_part;
  logic [NUM_BITS-1:0] div_hi, div_lo;
  logic [NUM_BITS:0]   add_sum;
  logic [NUM_BITS-1:0] sub_dif;
  logic [NUM_BITS-1:0] res_r;
  logic                res_c, res_v;

  assign multi = (op_q == OP_MUL) || (op_q == OP_DIV) || (op_q == OP_MOD);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EXEC;
      EXEC:    if (!multi || (cnt_q == '0)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == EXEC) || (state_q == FINISH);
    done = (state_q == FINISH);
  end

  // One shift-add step: add A when the current multiplier bit is set, then
  // shift the {carry, high, low} chain right by one.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    mul_hi  = mul_sum[NUM_BITS:1];
    mul_lo  = {mul_sum[0], lo_q[MSB:1]};
  end

  // One restoring-division step. The remainder stays below B, so after a
  // successful subtract the difference always fits in NUM_BITS bits.
  always_comb begin
    div_part = {hi_q, lo_q[MSB]};
    if (div_part >= {1'b0, b_q}) begin
      div_hi = div_part[MSB:0] - b_q;
      div_lo = {lo_q[MSB-1:0], 1'b1};
    end else begin
      div_hi = div_part[MSB:0];
      div_lo = {lo_q[MSB-1:0], 1'b0};
    end
  end

  assign add_sum = {1'b0, a_q} + {1'b0, b_q};
  assign sub_dif = a_q - b_q;

  // Result for the op finishing this cycle; multi-cycle ops use the final step.
  always_comb begin
    res_r = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_r = add_sum[MSB:0];
        res_c = add_sum[NUM_BITS];
        res_v = (a_q[MSB] == b_q[MSB]) && (add_sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        res_r = sub_dif;
        res_c = (a_q >= b_q);
        res_v = (a_q[MSB] != b_q[MSB]) && (sub_dif[MSB] != a_q[MSB]);
      end
      OP_MUL: begin
        res_r = mul_lo;
        res_v = |mul_hi;
      end
      OP_DIV: begin
        res_r = (b_q == '0) ? '1 : div_lo;
        res_v = (b_q == '0);
      end
      OP_MOD: begin
        res_r = (b_q == '0) ? '1 : div_hi;
        res_v = (b_q == '0);
      end
      OP_AND: res_r = a_q & b_q;
      OP_OR:  res_r = a_q | b_q;
      OP_XOR: res_r = a_q ^ b_q;
      OP_LSL: res_r = (b_q >= WIDTH_V) ? '0 : (a_q << b_q);
      OP_LSR: res_r = (b_q >= WIDTH_V) ? '0 : (a_q >> b_q);
`ifdef SEQ_ALU_ASR_EN
      OP_ASR: res_r = (b_q >= WIDTH_V) ? {NUM_BITS{a_q[MSB]}}
                                       : NUM_BITS'($signed(a_q) >>> b_q);
`endif
      default: res_r = '0;
    endcase
  end

  // Datapath: operand capture, iteration, and result/flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
      r_q   <= '0;
      n_q   <= 1'b0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        a_q   <= A;
        b_q   <= B;
        op_q  <= S;
        hi_q  <= '0;
        lo_q  <= (S == OP_MUL) ? B : A;
        cnt_q <= CW'(NUM_BITS - 1);
      end
      if (state_q == EXEC) begin
        if (op_q == OP_MUL) begin
          hi_q <= mul_hi;
          lo_q <= mul_lo;
        end else begin
          hi_q <= div_hi;
          lo_q <= div_lo;
        end
        cnt_q <= cnt_q - 1'b1;
        if (state_d == FINISH) begin
          r_q <= res_r;
          n_q <= res_r[MSB];
          z_q <= (res_r == '0);
          c_q <= res_c;
          v_q <= res_v;
        end
      end
    end
  end

  assign R = r_q;
  assign N = n_q;
  assign Z = z_q;
  assign C = c_q;
  assign V = v_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  typedef struct {
    logic [7:0] r;
    logic       n, z, c, v;
    int         lat;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a_drv = '0, b_drv = '0;
  logic [3:0] s_drv = '0;

  logic       busy4, done4, n4, z4, c4, v4;
  logic [3:0] r4;
  logic       busy8, done8, n8, z8, c8, v8;
  logic [7:0] r8;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q4[$];
  exp_t q8[$];
  logic [7:0] last4 = '0, last8 = '0;

  seq_alu #(.NUM_BITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(a_drv[3:0]), .B(b_drv[3:0]), .S(s_drv),
    .busy(busy4), .done(done4), .R(r4), .N(n4), .Z(z4), .C(c4), .V(v4)
  );

  seq_alu #(.NUM_BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(a_drv), .B(b_drv), .S(s_drv),
    .busy(busy8), .done(done8), .R(r8), .N(n8), .Z(z8), .C(c8), .V(v8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour from the arithmetic definition of each opcode.
  function automatic exp_t model(input int w, input logic [3:0] s,
                                 input logic [7:0] a8, input logic [7:0] b8);
    exp_t   e;
    longint a, b, sa, sb, m, half, full, r;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    a    = longint'(a8) & m;
    b    = longint'(b8) & m;
    sa   = (a >= half) ? a - (m + 1) : a;
    sb   = (b >= half) ? b - (m + 1) : b;
    r = 0; e.c = 1'b0; e.v = 1'b0; e.lat = 2; e.cyc = 0;
    case (s)
      4'h0: begin
        full = a + b; r = full & m; e.c = (full > m);
        e.v = ((sa + sb) >= half) || ((sa + sb) < -half);
      end
      4'h1: begin
        r = (a - b) & m; e.c = (a >= b);
        e.v = ((sa - sb) >= half) || ((sa - sb) < -half);
      end
      4'h2: begin
        full = a * b; r = full & m; e.v = (full > m); e.lat = w + 1;
      end
      4'h3: begin
        e.lat = w + 1;
        if (b == 0) begin r = m; e.v = 1'b1; end else r = a / b;
      end
      4'h4: begin
        e.lat = w + 1;
        if (b == 0) begin r = m; e.v = 1'b1; end else r = a % b;
      end
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = (b >= w) ? 0 : ((a << b) & m);
      4'hC: r = (b >= w) ? 0 : (a >> b);
`ifdef SEQ_ALU_ASR_EN
      4'hD: r = (b >= w) ? ((sa < 0) ? m : 0) : ((sa >>> b) & m);
`endif
      default: r = 0;
    endcase
    e.r = r[7:0];
    e.n = ((r >> (w - 1)) & 1) != 0;
    e.z = (r == 0);
    return e;
  endfunction

  // Monitor: pop the expected response whenever a done pulse is seen.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done4) begin
        if (q4.size() == 0) chk("done4_unexpected", 1, 0);
        else begin
          e = q4.pop_front();
          chk("r4", r4, e.r[3:0]); chk("n4", n4, e.n); chk("z4", z4, e.z);
          chk("c4", c4, e.c); chk("v4", v4, e.v); chk("done4_cycle", cyc, e.cyc);
        end
      end
      if (done8) begin
        if (q8.size() == 0) chk("done8_unexpected", 1, 0);
        else begin
          e = q8.pop_front();
          chk("r8", r8, e.r); chk("n8", n8, e.n); chk("z8", z8, e.z);
          chk("c8", c8, e.c); chk("v8", v8, e.v); chk("done8_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Issue one op to both DUTs; optionally pulse start again `glitch` cycles in.
  task automatic issue(input logic [3:0] s, input logic [7:0] a,
                       input logic [7:0] b, input int glitch);
    exp_t e4, e8;
    int   nb4, nb8, k;
    nb4 = 0; nb8 = 0; k = 0;
    @(negedge clk);
    e4 = model(4, s, a, b); e4.cyc = cyc + e4.lat;
    e8 = model(8, s, a, b); e8.cyc = cyc + e8.lat;
    q4.push_back(e4);
    q8.push_back(e8);
    a_drv = a; b_drv = b; s_drv = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_r4", r4, last4[3:0]);
    chk("hold_r8", r8, last8);
    while ((busy4 || busy8) && k < 40) begin
      if (busy4) nb4++;
      if (busy8) nb8++;
      if (glitch != 0 && k == glitch) begin
        start = 1'b1; a_drv = ~a; b_drv = b + 8'd1; s_drv = 4'h0;
      end else start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("busy_cycles4", nb4, e4.lat);
    chk("busy_cycles8", nb8, e8.lat);
    last4 = e4.r;
    last8 = e8.r;
  endtask

  initial begin
    logic [3:0] ops [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9,
                             4'hA, 4'hB, 4'hC, 4'hD, 4'h5, 4'h7, 4'hF};
    logic [3:0] op;
    logic [7:0] ra, rb;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy4", busy4, 0); chk("rst_done4", done4, 0); chk("rst_r4", r4, 0);
    chk("rst_nzcv4", {n4, z4, c4, v4}, 0);
    chk("rst_busy8", busy8, 0); chk("rst_done8", done8, 0); chk("rst_r8", r8, 0);
    chk("rst_nzcv8", {n8, z8, c8, v8}, 0);
    rst_n = 1'b1;

    // Directed vectors
    issue(4'h0, 8'b1001, 8'b0110, 0);
    issue(4'h2, 8'b0101, 8'b0011, 0);
    issue(4'h2, 8'b0100, 8'b0100, 0);
    issue(4'h3, 8'b1111, 8'b0011, 0);
    issue(4'h4, 8'b1111, 8'b1100, 0);
    issue(4'h3, 8'b1010, 8'b0000, 0);
    issue(4'h4, 8'hA5, 8'h00, 0);
    issue(4'h1, 8'h80, 8'h01, 0);
    issue(4'h1, 8'h03, 8'h05, 0);
    issue(4'h0, 8'h7F, 8'h01, 0);
    issue(4'hB, 8'h81, 8'h04, 0);
    issue(4'hC, 8'hF0, 8'h08, 0);
    issue(4'hD, 8'b10010000, 8'd2, 0);
    issue(4'hD, 8'h85, 8'd9, 0);
    issue(4'h6, 8'hFF, 8'hFF, 0);

    // Second start mid-mul must be ignored
    issue(4'h2, 8'h37, 8'h2B, 2);

    // Reset in the middle of a div: no done, state cleared
    @(negedge clk);
    a_drv = 8'hFF; b_drv = 8'h03; s_drv = 4'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; s_drv = 4'h0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    chk("abort_busy4", busy4, 0); chk("abort_busy8", busy8, 0);
    chk("abort_r4", r4, 0); chk("abort_r8", r8, 0);
    chk("abort_done8", done8, 0);
    @(negedge clk);
    chk("abort_start_ignored4", busy4, 0); chk("abort_start_ignored8", busy8, 0);
    last4 = '0; last8 = '0;
    issue(4'h0, 8'b1001, 8'b0110, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 13)];
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (op >= 4'hB && $urandom_range(0, 3) != 0) rb = 8'($urandom_range(0, 10));
      if ((op == 4'h3 || op == 4'h4) && $urandom_range(0, 5) == 0) rb = 8'h00;
      issue(op, ra, rb, 0);
    end

    repeat (5) @(negedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 8, giving the operand and result width (minimum 4).
REQ-002 Port clk  input  1  rising-edge clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
REQ-004 Port start  input  1  request strobe; samples A, B and S when accepted.
REQ-005 Port A  input  NUM_BITS  operand A.
REQ-006 Port B  input  NUM_BITS  operand B.
REQ-007 Port S  input  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 mod, 1000 and, 1001 or, 1010 xor, 1011 lshift, 1100 rshift.
REQ-008 Port busy  output  1  high while an operation is in progress.
REQ-009 Port done  output  1  one-cycle pulse when R and the flags are valid.
REQ-010 Port R  output  NUM_BITS  registered result.
REQ-011 Port N, Z, C, V  output  1 each  registered negative, zero, carry and overflow flags.

Function
REQ-012 The FSM SHALL have states IDLE, EXEC and FINISH: IDLE->EXEC on start, EXEC->FINISH when the operation completes, FINISH->IDLE unconditionally.
REQ-013 start SHALL be accepted only in IDLE; A, B and S are latched on acceptance; start in EXEC or FINISH is ignored.
REQ-014 busy SHALL be high in EXEC and FINISH; done SHALL be high only in FINISH.
REQ-015 R and the flags SHALL update only on entry to FINISH and hold their values until the next done.
REQ-016 Add, sub, logic and shift ops SHALL take one EXEC cycle: start at edge t gives done at edge t+2.
REQ-017 Mul SHALL use an iterative shift-add with one bit per cycle; div and mod SHALL use restoring division with one bit per cycle; each takes NUM_BITS EXEC cycles, so done comes at edge t+NUM_BITS+1.
REQ-018 Add: R = (A+B) mod 2^NUM_BITS; C = carry out; V = signed overflow.
REQ-019 Sub: R = (A-B) mod 2^NUM_BITS; C = 1 when A>=B (unsigned, no borrow); V = signed overflow.
REQ-020 Mul: R = low NUM_BITS bits of the unsigned product; V = 1 when the high half is nonzero; C = 0.
REQ-021 Div and mod are unsigned; div: R = A/B; mod: R = A mod B.
REQ-022 When B = 0, div and mod SHALL return R = all ones with V = 1 and C = 0, after the same latency.
REQ-023 Lshift and rshift are logical shifts by B; when B >= NUM_BITS, R SHALL be 0.
REQ-024 For and, or, xor and the shifts, C and V SHALL be 0.
REQ-025 For every op, N = R[NUM_BITS-1] and Z = (R==0).
REQ-026 An undefined opcode SHALL complete in one EXEC cycle with R = 0, Z = 1 and N = C = V = 0.

Reset
REQ-027 With rst_n low at a clock edge, the FSM SHALL go to IDLE and busy, done, R, N, Z, C and V SHALL all be 0.
REQ-028 Reset during EXEC or FINISH SHALL abort the operation with no done pulse; start is ignored while rst_n is low.

Configuration
REQ-029 With macro SEQ_ALU_ASR_EN defined, opcode 1101 SHALL be an arithmetic right shift by B that sign-fills; when B >= NUM_BITS, R = all copies of A[MSB]; C = V = 0.
REQ-030 Without SEQ_ALU_ASR_EN, opcode 1101 SHALL be undefined and follow REQ-026.

Verification
REQ-031 NUM_BITS=4, add A=1001 B=0110 -> done at t+2, R=1111, N=1, Z=0, C=0, V=0.
REQ-032 NUM_BITS=4, mul A=0101 B=0011 -> busy for 5 cycles, done at t+5, R=1111, V=0; then A=0100 B=0100 -> R=0000, Z=1, V=1.
REQ-033 NUM_BITS=4, div A=1111 B=0011 -> R=0101; mod A=1111 B=1100 -> R=0011; div with B=0 -> R=1111, V=1.
REQ-034 Start pulsed again in the middle of a mul with different operands -> ignored; the first result is returned unchanged and exactly one done pulse occurs.
REQ-035 rst_n low for one edge in the middle of a div -> busy=0 and R=0 at the next cycle, no done pulse; a new add then completes normally.
REQ-036 NUM_BITS=8, opcode 1101 with A=10010000 B=2 -> R=11100100 with SEQ_ALU_ASR_EN defined; R=0 and Z=1 without it.
